score_display: RTL
==================

Name: score_display

Overview:
- Downstream consumer of the scoreboard up/down counter (count range 0-99).
- Converts the 7-bit binary count to two BCD digits with a sequential subtract-by-ten engine.
- Time-multiplexes the tens and ones digits onto one shared 7-segment bus with one-hot digit enables.
- Sits between the counter output and the board's dual-digit display.

Parameters:
- BW, 7, width of cnt_i; must be >= 7.
- REFRESH_DIV, 1000, clock cycles each digit stays selected; minimum 1.
- LEAD_BLANK, 1, when 1 the tens digit is blanked if it is zero and there is no overflow.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset, asynchronous, active-high.
- cnt_i  input  BW  binary score from the counter.
- seg_o  output  7  segments {g,f,e,d,c,b,a}, active-high, registered.
- dig_sel_o  output  2  one-hot digit enable (01 = ones, 10 = tens), registered.
- busy_o  output  1  high while a conversion is in progress.

Behaviour:
- Fixed decisions: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: seg_o=0, dig_sel_o=01, busy_o=0, tens_q=ones_q=0, ovf_q=0, last_q=0, state=IDLE, refresh counter=0.
- FSM states: IDLE, CONVERT, DONE.
- IDLE:
  - Compares cnt_i with last_q every cycle.
  - On mismatch at edge N: last_q<=cnt_i, work<=cnt_i, tens_tmp<=0.
  - If cnt_i<=99, go to CONVERT; if cnt_i>99, go to DONE with ovf_tmp=1.
- CONVERT:
  - Each edge with work>=10: work-=10, tens_tmp+=1.
  - Edge with work<10: ones_tmp<=work[3:0], ovf_tmp=0, go to DONE.
- DONE: the next edge commits tens_q/ones_q/ovf_q from the tmp values and returns to IDLE.
- Latency for value v<=99, k=floor(v/10):
  - Commit happens at edge N+k+2.
  - busy_o is high for exactly k+2 cycles.
- Latency for v>99: commit at edge N+1; busy_o is high for 1 cycle.
- cnt_i changes while busy_o=1 are ignored. After returning to IDLE, the last_q mismatch starts a new conversion, so the final stable value is always displayed.
- Refresh:
  - Counter runs 0..REFRESH_DIV-1 and wraps.
  - dig_sel_o toggles between 01 and 10 on the wrap edge.
  - With REFRESH_DIV=1 it toggles every cycle.
- Segment output:
  - Every edge, seg_o <= decode(digit selected by the dig_sel_o value loaded on that same edge, current tens_q/ones_q/ovf_q).
  - seg_o therefore lags a commit by one cycle and never shows a mismatched digit/enable pair.
- Decode table: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F.
- ovf_q=1: both digits show 40 (dash, segment g only).
- LEAD_BLANK=1 with tens_q=0 and ovf_q=0: tens digit shows 00.
- Upper cnt_i bits beyond bit 6 count toward the >99 test.
- Reset mid-conversion:
  - Aborts the conversion immediately (asynchronous) and returns all registers to reset values.
  - After release, last_q=0, so any nonzero cnt_i is reconverted.

Test Plan:
- Reset, then cnt_i=0 held, REFRESH_DIV=4:
  - busy_o never rises.
  - dig_sel_o alternates 01/10 every 4 cycles.
  - seg_o=3F while ones is selected and 00 while tens is selected.
- cnt_i 0->47:
  - busy_o high exactly 6 cycles.
  - Afterwards seg_o=07 with dig_sel 01 and 66 with dig_sel 10.
- cnt_i=99:
  - busy_o high 11 cycles; both digits show 6F.
  - Then cnt_i=100: busy_o high 1 cycle; both digits show 40.
- cnt_i=99, then 5 two cycles later:
  - 99 is committed first.
  - A second conversion of 5 follows (busy 2 cycles).
  - Final display: ones 6D, tens 00.
- cnt_i=95, rst_i asserted 3 cycles into the conversion:
  - seg_o=0, dig_sel_o=01, busy_o=0 immediately, without waiting for a clock edge.
  - After release, 95 is reconverted (busy 11 cycles); display shows 6F/6D.
- LEAD_BLANK=0, cnt_i=7: tens digit shows 3F, ones digit shows 07.

Source files
------------

// File: rtl/score_display.sv
// rtl/score_display.sv - binary score to two multiplexed 7-segment digits
// Subtract-by-ten BCD conversion feeding a time-multiplexed dual-digit display.
module score_display #(
    parameter int BW          = 7,
    parameter int REFRESH_DIV = 1000,
    parameter int LEAD_BLANK  = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [BW-1:0] cnt_i,
    output logic [6:0]    seg_o,
    output logic [1:0]    dig_sel_o,
    output logic          busy_o
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [BW-1:0] r_last;
    logic [6:0]    r_work;
    logic [3:0]    r_tens_tmp;
    logic [3:0]    r_ones_tmp;
    logic          r_ovf_tmp;
    logic [3:0]    r_tens_q;
    logic [3:0]    r_ones_q;
    logic          r_ovf_q;
    logic [RW-1:0] r_refresh;
    logic [1:0]    r_dig_sel;
    logic [6:0]    r_seg;

    logic       w_mismatch;
    logic       w_over;
    logic       w_work_ge10;
    logic       w_wrap;
    logic [1:0] w_dig_next;
    logic [3:0] w_digit;
    logic [6:0] w_seg_next;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'h3F;
            4'd1:    f_decode = 7'h06;
            4'd2:    f_decode = 7'h5B;
            4'd3:    f_decode = 7'h4F;
            4'd4:    f_decode = 7'h66;
            4'd5:    f_decode = 7'h6D;
            4'd6:    f_decode = 7'h7D;
            4'd7:    f_decode = 7'h07;
            4'd8:    f_decode = 7'h7F;
            4'd9:    f_decode = 7'h6F;
            default: f_decode = 7'h40;
        endcase
    endfunction

    // Every bit of cnt_i takes part in the range test, so wide counters overflow too.
    assign w_mismatch  = (cnt_i != r_last);
    assign w_over      = (cnt_i > BW'(99));
    assign w_work_ge10 = (r_work >= 7'd10);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_mismatch) begin
                    w_state_next = w_over ? DONE : CONVERT;
                end
            end
            CONVERT: begin
                if (!w_work_ge10) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last     <= '0;
            r_work     <= '0;
            r_tens_tmp <= '0;
            r_ones_tmp <= '0;
            r_ovf_tmp  <= 1'b0;
            r_tens_q   <= '0;
            r_ones_q   <= '0;
            r_ovf_q    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mismatch) begin
                        r_last     <= cnt_i;
                        r_work     <= cnt_i[6:0];
                        r_tens_tmp <= '0;
                        if (w_over) begin
                            r_ovf_tmp <= 1'b1;
                        end
                    end
                end
                CONVERT: begin
                    if (w_work_ge10) begin
                        r_work     <= r_work - 7'd10;
                        r_tens_tmp <= r_tens_tmp + 4'd1;
                    end else begin
                        r_ones_tmp <= r_work[3:0];
                        r_ovf_tmp  <= 1'b0;
                    end
                end
                DONE: begin
                    r_tens_q <= r_tens_tmp;
                    r_ones_q <= r_ones_tmp;
                    r_ovf_q  <= r_ovf_tmp;
                end
                default: ;
            endcase
        end
    end

    assign w_wrap     = (r_refresh == REFRESH_MAX);
    assign w_dig_next = w_wrap ? {r_dig_sel[0], r_dig_sel[1]} : r_dig_sel;
    assign w_digit    = w_dig_next[1] ? r_tens_q : r_ones_q;

    // Segments are decoded for the enable being loaded on the same edge, keeping the pair aligned.
    always_comb begin
        w_seg_next = f_decode(w_digit);
        if (r_ovf_q) begin
            w_seg_next = 7'h40;
        end else if (w_dig_next[1] && (LEAD_BLANK != 0) && (r_tens_q == 4'd0)) begin
            w_seg_next = 7'h00;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_refresh <= '0;
            r_dig_sel <= 2'b01;
            r_seg     <= 7'h00;
        end else begin
            r_refresh <= w_wrap ? '0 : r_refresh + RW'(1);
            r_dig_sel <= w_dig_next;
            r_seg     <= w_seg_next;
        end
    end

    assign seg_o     = r_seg;
    assign dig_sel_o = r_dig_sel;
    assign busy_o    = (r_state != IDLE);

endmodule
